// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA block mover.
package dma_pkg;

   localparam int unsigned BEATS      = 32;
   localparam int unsigned BEAT_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_e;

endpackage

// File: rtl/dma_block_shreg.sv
// Word-addressable block register: parallel load, one word write port,
// one combinational word read port and a parallel output.
module dma_block_shreg #(
   parameter int unsigned DATA_W = 1024,
   parameter int unsigned BUS_W  = 32,
   localparam int unsigned NWORDS = DATA_W / BUS_W,
   localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [BUS_W-1:0]  wr_data_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [BUS_W-1:0]  rd_data_c,
   output logic [DATA_W-1:0] data_o
);

   logic [BUS_W-1:0] word_q [NWORDS];
   logic [BUS_W-1:0] word_d [NWORDS];

   // Load has priority over a single-word write.
   always_comb begin
      word_d = word_q;
      if (load_i) begin
         for (int unsigned i = 0; i < NWORDS; i++) begin
            word_d[i] = load_data_i[i*BUS_W +: BUS_W];
         end
      end else if (wr_en_i) begin
         word_d[wr_idx_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NWORDS; i++) begin
            word_q[i] <= '0;
         end
      end else begin
         word_q <= word_d;
      end
   end

   assign rd_data_c = word_q[rd_idx_i];

   for (genvar g = 0; g < NWORDS; g++) begin : g_out
      assign data_o[g*BUS_W +: BUS_W] = word_q[g];
   end

endmodule

// File: rtl/dma_block_mover.sv
// Single-outstanding DMA responder moving one DATA_W block per request as
// BUS_W beats. Optional feature: DMA_ALIGN_CHECK_EN (reject misaligned bases).
module dma_block_mover
   import dma_pkg::*;
#(
   parameter int unsigned DATA_W = 1024,
   parameter int unsigned BUS_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              dma_rx_start,
   input  logic              dma_tx_start,
   input  logic [31:0]       dma_rx_address,
   input  logic [31:0]       dma_tx_address,
   input  logic [DATA_W-1:0] dma_tx_data,
   output logic [DATA_W-1:0] dma_rx_data,
   output logic              dma_idle,
   output logic              dma_done,
   output logic              dma_error,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [BUS_W-1:0]  mem_wdata,
   input  logic              mem_ready,
   input  logic [BUS_W-1:0]  mem_rdata,
   input  logic              mem_err
);

   localparam int unsigned NBEATS = DATA_W / BUS_W;
   localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   dma_state_e       state_q, state_d;
   logic [CNT_W-1:0] beat_q, beat_d, beat_nxt_c;
   logic [31:0]      base_q, base_d;
   logic [31:0]      addr_q, addr_d;
   logic [BUS_W-1:0] wdata_q, wdata_d;
   logic             idle_q, idle_d, done_q, done_d, error_q, error_d;
   logic             req_q, req_d, we_q, we_d;

   logic             accept_c, acc_tx_c, misalign_c, beat_fire_c, last_beat_c;
   logic             load_c, cap_c;
   logic [31:0]      start_addr_c, aligned_c;
   logic [BUS_W-1:0] tx_word_c;
   logic [BUS_W-1:0] rx_word_unused;
   logic [DATA_W-1:0] tx_blk_unused;

   // RX wins when both starts are seen in IDLE.
   assign accept_c     = (state_q == ST_IDLE) && (dma_rx_start || dma_tx_start);
   assign acc_tx_c     = (state_q == ST_IDLE) && dma_tx_start && !dma_rx_start;
   assign start_addr_c = dma_rx_start ? dma_rx_address : dma_tx_address;
   assign aligned_c    = {start_addr_c[31:2], 2'b00};
`ifdef DMA_ALIGN_CHECK_EN
   assign misalign_c   = |start_addr_c[1:0];
`else
   logic [1:0] addr_lsb_unused;
   assign addr_lsb_unused = start_addr_c[1:0];
   assign misalign_c   = 1'b0;
`endif

   assign beat_fire_c = ((state_q == ST_READ) || (state_q == ST_WRITE)) && mem_ready;
   assign last_beat_c = (beat_q == CNT_W'(NBEATS - 1));
   assign beat_nxt_c  = beat_q + CNT_W'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         idle_q  <= idle_d;
         done_q  <= done_d;
         error_q <= error_d;
         req_q   <= req_d;
         we_q    <= we_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (misalign_c)        state_d = ST_DONE;
               else if (dma_rx_start) state_d = ST_READ;
               else                   state_d = ST_WRITE;
            end
         end
         ST_READ, ST_WRITE: begin
            if (mem_ready && (mem_err || last_beat_c)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs follow the next state; beat data advances only on acceptance.
   always_comb begin : out_comb
      base_d  = base_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      error_d = error_q;
      idle_d  = (state_d == ST_IDLE);
      done_d  = (state_d == ST_DONE);
      req_d   = (state_d == ST_READ) || (state_d == ST_WRITE);
      we_d    = (state_d == ST_WRITE);
      load_c  = 1'b0;
      cap_c   = 1'b0;
      if (accept_c) begin
         base_d  = aligned_c;
         beat_d  = '0;
         addr_d  = aligned_c;
         error_d = misalign_c;
         if (acc_tx_c) begin
            load_c  = 1'b1;
            wdata_d = dma_tx_data[BUS_W-1:0];
         end
      end else if (beat_fire_c) begin
         if (mem_err) begin
            error_d = 1'b1;
         end else begin
            cap_c = (state_q == ST_READ);
            if (!last_beat_c) begin
               beat_d  = beat_nxt_c;
               addr_d  = base_q + 32'(beat_nxt_c) * 32'(BEAT_BYTES);
               wdata_d = tx_word_c;
            end
         end
      end
   end

   dma_block_shreg #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_tx_blk (
      .clk         (clk),
      .resetn      (resetn),
      .load_i      (load_c),
      .load_data_i (dma_tx_data),
      .wr_en_i     (1'b0),
      .wr_idx_i    ('0),
      .wr_data_i   ('0),
      .rd_idx_i    (beat_nxt_c),
      .rd_data_c   (tx_word_c),
      .data_o      (tx_blk_unused)
   );

   // Separate RX store so a TX never disturbs the last read block.
   dma_block_shreg #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_rx_blk (
      .clk         (clk),
      .resetn      (resetn),
      .load_i      (1'b0),
      .load_data_i ('0),
      .wr_en_i     (cap_c),
      .wr_idx_i    (beat_q),
      .wr_data_i   (mem_rdata),
      .rd_idx_i    ('0),
      .rd_data_c   (rx_word_unused),
      .data_o      (dma_rx_data)
   );

   assign dma_idle  = idle_q;
   assign dma_done  = done_q;
   assign dma_error = error_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dma_block_mover.sv
// Randomized scoreboard bench for dma_block_mover with a word-array memory model.
module tb_dma_block_mover;

   localparam int DW = 1024;
   localparam int BW = 32;
   localparam int NB = DW / BW;

   logic          clk, resetn;
   logic          dma_rx_start, dma_tx_start;
   logic [31:0]   dma_rx_address, dma_tx_address;
   logic [DW-1:0] dma_tx_data, dma_rx_data;
   logic          dma_idle, dma_done, dma_error;
   logic          mem_req, mem_we, mem_ready, mem_err;
   logic [31:0]   mem_addr;
   logic [BW-1:0] mem_wdata, mem_rdata;

   dma_block_mover dut (
      .clk(clk), .resetn(resetn),
      .dma_rx_start(dma_rx_start), .dma_tx_start(dma_tx_start),
      .dma_rx_address(dma_rx_address), .dma_tx_address(dma_tx_address),
      .dma_tx_data(dma_tx_data), .dma_rx_data(dma_rx_data),
      .dma_idle(dma_idle), .dma_done(dma_done), .dma_error(dma_error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
   typedef struct { logic err; logic [DW-1:0] rx; } done_t;

   beat_t       exp_beats[$];
   done_t       exp_done[$];
   int          checks = 0;
   int          failures = 0;
   int          ready_pct = 100;
   int          err_beat = -1;
   int          stall_total = 0;
   logic [31:0] mem [1024];
   logic [31:0] ref_mem [1024];
   logic [DW-1:0] exp_rx;

   function automatic logic [31:0] init_word(input int i);
      if (i >= 'h40 && i < 'h60) return 32'h1000 + 32'(i - 'h40);
      return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_blk(input logic [DW-1:0] act, input logic [DW-1:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory responder and beat monitor: pops one expected beat per accepted beat.
   initial begin : mem_model
      bit rdy, er, stalled;
      int idx, xfer_beat;
      logic [31:0] s_addr, s_wdata;
      logic s_we;
      beat_t e;
      stalled = 0; xfer_beat = 0; s_addr = 0; s_wdata = 0; s_we = 0;
      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
      mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn && mem_req) begin
            if (stalled)
               chk(mem_addr == s_addr && mem_we == s_we && mem_wdata == s_wdata, "stall_stable",
                   {mem_we, mem_addr}, {s_we, s_addr});
            rdy = ($urandom_range(99) < 32'(ready_pct));
            if (rdy) begin
               idx = int'(mem_addr[11:2]);
               er = (xfer_beat == err_beat);
               mem_ready = 1'b1; mem_err = er; mem_rdata = mem[idx];
               if (exp_beats.size() == 0) begin
                  chk(1'b0, "unexpected_beat", {32'(xfer_beat), mem_addr}, 64'h0);
               end else begin
                  e = exp_beats.pop_front();
                  chk(mem_addr == e.addr, "beat_addr", mem_addr, e.addr);
                  chk(mem_we == e.we, "beat_we", mem_we, e.we);
                  if (e.we) chk(mem_wdata == e.wdata, "beat_wdata", mem_wdata, e.wdata);
               end
               if (mem_we && !er) mem[idx] = mem_wdata;
               xfer_beat++; stalled = 0;
            end else begin
               mem_ready = 1'b0; mem_err = 1'($urandom_range(1)); mem_rdata = $urandom;
               stalled = 1; s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
               stall_total++;
            end
         end else begin
            mem_ready = 1'($urandom_range(1)); mem_err = 1'b0; mem_rdata = $urandom;
            xfer_beat = 0; stalled = 0;
         end
      end
   end

   // Completion monitor.
   initial begin : done_mon
      done_t d;
      forever begin
         @(negedge clk);
         if (resetn && dma_done) begin
            if (exp_done.size() == 0) begin
               chk(1'b0, "spurious_done", 64'(dma_done), 64'h0);
            end else begin
               d = exp_done.pop_front();
               chk(dma_error == d.err, "done_error", 64'(dma_error), 64'(d.err));
               chk_blk(dma_rx_data, d.rx, "rx_data");
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!dma_idle && n < 200) begin @(posedge clk); #1; n++; end
      if (!dma_idle) chk(1'b0, "idle_timeout", 64'(n), 64'd200);
   endtask

   // One transfer: model the expected beats, block and memory, then drive it.
   task automatic do_xfer(input bit is_rx, input bit both, input logic [31:0] addr,
                          input int eb, input int rpct, input bit hold, input bit dead5);
      logic [31:0]   base;
      logic [DW-1:0] blk;
      bit            mis;
      int            nb, ok_words, n, s0, exp_lat;
      done_t         d;
      wait_idle();
`ifdef DMA_ALIGN_CHECK_EN
      mis = |addr[1:0];
`else
      mis = 1'b0;
`endif
      base = {addr[31:2], 2'b00};
      for (int i = 0; i < NB; i++) blk[i*BW +: BW] = $urandom;
      if (dead5) blk[5*BW +: BW] = 32'hDEADBEEF;
      nb = mis ? 0 : ((eb >= 0) ? eb + 1 : NB);
      ok_words = (eb >= 0) ? eb : nb;
      for (int i = 0; i < nb; i++) begin
         beat_t b;
         b.addr = base + 32'(4 * i); b.we = !is_rx; b.wdata = blk[i*BW +: BW];
         exp_beats.push_back(b);
      end
      for (int i = 0; i < ok_words; i++) begin
         int w = int'(base[11:2]) + i;
         if (is_rx) exp_rx[i*BW +: BW] = ref_mem[w];
         else       ref_mem[w] = blk[i*BW +: BW];
      end
      d.err = mis || (eb >= 0); d.rx = exp_rx;
      exp_done.push_back(d);
      err_beat = eb; ready_pct = rpct;
      dma_tx_data = blk;
      if (is_rx) begin
         dma_rx_start = 1'b1; dma_rx_address = addr;
         dma_tx_start = both; dma_tx_address = 32'($urandom_range(0, 991)) * 4;
      end else begin
         dma_tx_start = 1'b1; dma_tx_address = addr;
      end
      s0 = stall_total;
      @(posedge clk); #1; n = 1;
      if (mis)
         chk(dma_done && dma_error && !mem_req, "misalign_c1", {dma_done, dma_error, mem_req}, 3'b110);
      else
         chk(!dma_idle && mem_req && !dma_error && (mem_we == !is_rx), "cycle1",
             {dma_idle, mem_req, dma_error, mem_we}, {3'b010, !is_rx});
      dma_tx_data = ~blk;
      if (!hold) begin dma_rx_start = 1'b0; dma_tx_start = 1'b0; end
      while (!dma_done && n < 3000) begin @(posedge clk); #1; n++; end
      dma_rx_start = 1'b0; dma_tx_start = 1'b0;
      if (!dma_done) begin
         chk(1'b0, "done_timeout", 64'(n), 64'd3000);
      end else begin
         exp_lat = nb + 1 + (stall_total - s0);
         chk(n == exp_lat, "latency", 64'(n), 64'(exp_lat));
      end
      @(posedge clk); #1;
      chk(dma_idle && !dma_done && (dma_error == d.err), "post_done",
          {dma_idle, dma_done, dma_error}, {2'b10, d.err});
   endtask

   task automatic chk_mem(input string nm);
      int bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk(bad == 0, nm, 64'(bad), 64'd0);
   endtask

   initial begin : main
      exp_rx = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      resetn = 1'b0; dma_rx_start = 1'b0; dma_tx_start = 1'b0;
      dma_rx_address = '0; dma_tx_address = '0; dma_tx_data = '0;
      #23;
      chk(dma_idle && !dma_done && !dma_error && !mem_req && !mem_we, "reset_ctl",
          {dma_idle, dma_done, dma_error, mem_req, mem_we}, 5'b10000);
      chk(mem_addr == 0 && mem_wdata == 0, "reset_bus", {mem_addr, mem_wdata}, 64'h0);
      chk_blk(dma_rx_data, '0, "reset_rx_data");
      @(posedge clk); #1; resetn = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      do_xfer(1'b1, 1'b0, 32'h100, -1, 100, 1'b0, 1'b0);
      chk(dma_rx_data[31:0] == 32'h1000, "rx_word0", dma_rx_data[31:0], 32'h1000);
      chk(dma_rx_data[1023:992] == 32'h101F, "rx_word31", dma_rx_data[1023:992], 32'h101F);

      do_xfer(1'b0, 1'b0, 32'h400, -1, 100, 1'b0, 1'b1);
      chk(mem[('h400 + 'h14) >> 2] == 32'hDEADBEEF, "tx_word5", mem[('h400 + 'h14) >> 2], 32'hDEADBEEF);
      chk_mem("tx_mem");

      for (int k = 0; k < 3; k++)
         do_xfer(1'b1, 1'b0, 32'($urandom_range(0, 991)) * 4, -1, 50, 1'b0, 1'b0);

      do_xfer(1'b0, 1'b0, 32'h800, 10, 70, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk(dma_error == 1'b1, "error_sticky", 64'(dma_error), 64'd1);
      chk_mem("tx_err_mem");

      do_xfer(1'b1, 1'b1, 32'h600, -1, 80, 1'b1, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      chk(dma_idle && !mem_req, "no_queued_tx", {dma_idle, mem_req}, 2'b10);

      for (int k = 0; k < 6; k++) begin
         bit rx = 1'($urandom_range(1));
         int eb = (!rx && $urandom_range(2) == 0) ? int'($urandom_range(31)) : -1;
         do_xfer(rx, 1'b0, 32'($urandom_range(0, 991)) * 4, eb, int'($urandom_range(40, 100)), 1'b0, 1'b0);
      end
      chk_mem("mix_mem");

      // Reset while beat 7 is on the bus.
      wait_idle();
      ready_pct = 100; err_beat = -1;
      for (int i = 0; i < 7; i++) begin
         beat_t b;
         b.addr = 32'h200 + 32'(4 * i); b.we = 1'b0; b.wdata = '0;
         exp_beats.push_back(b);
      end
      dma_rx_start = 1'b1; dma_rx_address = 32'h200;
      @(posedge clk); #1; dma_rx_start = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      chk(mem_req == 1'b1, "pre_reset_req", 64'(mem_req), 64'd1);
      resetn = 1'b0; #1;
      chk(!mem_req && !dma_done && dma_idle, "reset_mid", {mem_req, dma_done, dma_idle}, 3'b001);
      exp_rx = '0;
      chk_blk(dma_rx_data, exp_rx, "reset_mid_rx");
      chk(exp_beats.size() == 0, "reset_beats_seen", 64'(exp_beats.size()), 64'd0);
      @(posedge clk); #1; resetn = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk(dma_idle && !dma_done && !mem_req, "post_reset", {dma_idle, dma_done, mem_req}, 3'b100);

      do_xfer(1'b1, 1'b0, 32'h102, -1, 100, 1'b0, 1'b0);
      do_xfer(1'b0, 1'b0, 32'hA00, -1, 60, 1'b0, 1'b0);
      chk_mem("final_mem");

      repeat (5) begin @(posedge clk); #1; end
      chk(exp_beats.size() == 0, "beats_drained", 64'(exp_beats.size()), 64'd0);
      chk(exp_done.size() == 0, "done_drained", 64'(exp_done.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_block_mover.md
# dma_block_mover

DMA responder that serves the block-transfer requests issued by the RSA accelerator's control FSM. Each request moves one 1024-bit operand block. An RX request reads the block from system memory; a TX request writes a block to system memory. Transfers run as 32-bit beats on a simple single-outstanding memory bus. The block drives the `dma_idle`/`dma_done`/`dma_error` handshake that the accelerator consumes.

## Interface
Parameters:
- `DATA_W`, 1024, block width in bits.
- `BUS_W`, 32, memory beat width; `BEATS = DATA_W/BUS_W` (32). `DATA_W` must be a multiple of `BUS_W`.

Ports:
- `clk` in 1: the single clock; all logic on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `dma_rx_start` in 1: request read of one block from `dma_rx_address`.
- `dma_tx_start` in 1: request write of `dma_tx_data` to `dma_tx_address`.
- `dma_rx_address` in 32: byte address of the RX block.
- `dma_tx_address` in 32: byte address of the TX block.
- `dma_tx_data` in DATA_W: block to write.
- `dma_rx_data` out DATA_W: block read; valid from the `dma_done` cycle, held until the next accepted RX.
- `dma_idle` out 1: engine idle; accepts a start.
- `dma_done` out 1: one-cycle completion pulse, for success or error.
- `dma_error` out 1: last transfer failed; sticky until the next accepted start.
- `mem_req` out 1: beat request.
- `mem_we` out 1: 1 = write beat.
- `mem_addr` out 32: beat byte address.
- `mem_wdata` out BUS_W: write beat data.
- `mem_ready` in 1: beat accepted/completed this cycle.
- `mem_rdata` in BUS_W: read data, valid when `mem_ready` is high.
- `mem_err` in 1: bus error, qualified by `mem_ready`.

## Operation
- States are IDLE, READ, WRITE and DONE.
- **IDLE**
  - `dma_idle` is 1.
  - A start seen here is accepted.
  - If `dma_rx_start` and `dma_tx_start` are both high, RX wins and the TX request is dropped.
  - On accept:
    - latch the base address;
    - clear the beat counter (5 bits for 32 beats);
    - clear `dma_error`;
    - for TX only, snapshot `dma_tx_data` into the shift register.
  - Go to READ or WRITE.
- **READ/WRITE**
  - `mem_req` is held high.
  - `mem_addr` = base + 4·beat.
  - Beat *i* maps to block bits [32i+31:32i], so word 0 is at the lowest address.
  - READ: on `mem_ready`, write `mem_rdata` into word *beat* of `dma_rx_data`.
  - WRITE: `mem_wdata` = word *beat* of the snapshot.
  - The address, data and `mem_we` outputs stay stable while `mem_req` is high and `mem_ready` is low.
  - On `mem_ready` with beat = BEATS−1, or on `mem_ready` with `mem_err` high, go to DONE.
  - `mem_err` sets `dma_error` and aborts the remaining beats.
  - On an aborted RX, `dma_rx_data` keeps whatever words were already written.
- **DONE**
  - `dma_done` = 1 for exactly this one cycle.
  - `mem_req` = 0.
  - Return to IDLE.
- Starts that arrive outside IDLE are ignored and not queued. The initiator holds start until it sees `dma_idle` fall.
- Reset values:
  - `dma_idle` = 1;
  - `dma_done`, `dma_error` and `mem_req` = 0;
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0;
  - `dma_rx_data` = 0;
  - state = IDLE.
- Reset asserted mid-transfer:
  - aborts immediately and asynchronously;
  - `mem_req` drops the same instant;
  - no `dma_done` pulse is produced.

## Timing
- All outputs are registered.
- Start accepted at edge 0 → `dma_idle` is 0 and `mem_req` is 1 from cycle 1.
- With zero-wait memory (`mem_ready` always 1):
  - beats occur in cycles 1–32;
  - `dma_done` in cycle 33;
  - `dma_idle` is 1 in cycle 34.
- Each wait cycle (`mem_ready` = 0) adds exactly one cycle.
- `dma_rx_data` is final in the `dma_done` cycle.
- A new start can be accepted in the first cycle `dma_idle` is 1.

## Configuration
- `DMA_ALIGN_CHECK_EN` defined:
  - a start whose address has bits [1:0] ≠ 0 is accepted;
  - it issues no bus beats and goes directly to DONE with `dma_error` = 1;
  - `dma_done` therefore pulses in cycle 1.
- `DMA_ALIGN_CHECK_EN` undefined:
  - address bits [1:0] are forced to 0 at latch time;
  - no alignment error is possible.

## Structure
- The shared package `dma_pkg` holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - `BEATS`;
  - the `BEAT_BYTES` = 4 constant.
- One sub-module, `dma_block_shreg`, is natural. It is the DATA_W-bit block register with:
  - a parallel load (TX snapshot);
  - word-indexed read (TX beat data);
  - word-indexed write (RX beat capture);
  - the parallel output that drives `dma_rx_data`.

## Test plan
- RX, zero-wait memory, words = index+0x1000 at base 0x100 → 32 reads at addresses 0x100…0x17C; `dma_done` in cycle 33; `dma_rx_data[31:0]` = 0x1000 and `[1023:992]` = 0x101F; `dma_error` = 0.
- TX of 0xDEADBEEF in word 5, with `dma_tx_data` changed after accept → `mem_we` = 1; beat 5 at base+0x14 carries 0xDEADBEEF (snapshot value); memory contents match the snapshot.
- Random `mem_ready` stalls (~50%) on RX → outputs stable during stalls; total latency = 33 + wait cycles; data intact.
- `mem_err` on beat 10 of TX → no beats after beat 10; `dma_done` pulses; `dma_error` = 1 until the next accepted start clears it.
- `dma_rx_start` and `dma_tx_start` both high in IDLE, plus start held high while busy → RX only, exactly one transfer, no queued TX.
- `resetn` low at beat 7 → `mem_req` = 0 immediately, no `dma_done`, `dma_idle` = 1. With `DMA_ALIGN_CHECK_EN` defined, an RX to 0x102 → no beats, `dma_done` and `dma_error` in cycle 1.
